// File: rtl/plot_scheduler.sv
// rtl/plot_scheduler.sv - column-by-column function plot sequencer
//
// Purpose: for each screen column, launches an RPN evaluation at that
// column's x, converts the 8.8 result into a screen row and issues one
// framebuffer write when the row is on-screen. Parsing is launched once
// per run, before the first column.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start               plot request, accepted only in IDLE or DONE
//   parser_start        one-cycle pulse launching the expression parse
//   parser_ready        level from parser, output queue complete
//   eval_start          one-cycle pulse launching evaluation at eval_x
//   eval_x              signed 8.8 x of the current column
//   eval_done           one-cycle pulse, eval_result/eval_error valid
//   eval_result         signed 8.8 f(x)
//   eval_error          evaluation failed, qualified by eval_done
//   pixel_we            one-cycle framebuffer write strobe
//   pixel_x, pixel_y    write coordinates, valid with pixel_we
//   busy                high outside IDLE and DONE
//   done                level, high in DONE until next accepted start
//   skipped_count       saturating count of columns lost to error/timeout
module plot_scheduler #(
    parameter int                      NUMBER_WIDTH  = 16,
    parameter int                      SCREEN_WIDTH  = 64,
    parameter int                      SCREEN_HEIGHT = 48,
    parameter logic [NUMBER_WIDTH-1:0] X_START       = 16'hE000,
    parameter logic [NUMBER_WIDTH-1:0] X_STEP        = 16'h0100,
    parameter int                      Y_ORIGIN      = 24,
    parameter int                      TIMEOUT       = 1024,
    localparam int                     COL_W         = $clog2(SCREEN_WIDTH),
    localparam int                     ROW_W         = $clog2(SCREEN_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    parser_start,
    input  logic                    parser_ready,
    output logic                    eval_start,
    output logic [NUMBER_WIDTH-1:0] eval_x,
    input  logic                    eval_done,
    input  logic [NUMBER_WIDTH-1:0] eval_result,
    input  logic                    eval_error,
    output logic                    pixel_we,
    output logic [COL_W-1:0]        pixel_x,
    output logic [ROW_W-1:0]        pixel_y,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              skipped_count
);

    localparam int FRAC_W = 8;
    localparam int INT_W  = NUMBER_WIDTH - FRAC_W;
    localparam int CALC_A = COL_W + ROW_W + 2;
    localparam int CALC_B = INT_W + 2;
    // Row arithmetic is wide enough that no result value can wrap into range.
    localparam int CALC_W = (CALC_A > CALC_B) ? CALC_A : CALC_B;
    localparam int WD_W   = $clog2(TIMEOUT) + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PARSE,
        S_PARSE_GAP,
        S_WAIT_PARSE,
        S_EVAL,
        S_WAIT_EVAL,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [COL_W-1:0]         r_col;
    logic [WD_W-1:0]          r_watchdog;
    logic [NUMBER_WIDTH-1:0]  r_eval_x;
    logic                     r_parser_start;
    logic                     r_eval_start;
    logic                     r_pixel_we;
    logic [COL_W-1:0]         r_pixel_x;
    logic [ROW_W-1:0]         r_pixel_y;
    logic                     r_busy;
    logic                     r_done;
    logic [7:0]               r_skipped;

    logic signed [CALC_W-1:0] w_row;
    logic                     w_row_ok;
    logic [WD_W-1:0]          w_wd_next;
    logic                     w_wd_expire;
    logic [7:0]               w_skip_sat;
    logic                     w_unused_frac;

    // Floor of the result is its integer byte; screen rows grow downward.
    assign w_row = $signed(CALC_W'(Y_ORIGIN))
                 - $signed({{(CALC_W-INT_W){eval_result[NUMBER_WIDTH-1]}},
                            eval_result[NUMBER_WIDTH-1:FRAC_W]});
    assign w_row_ok = !w_row[CALC_W-1]
                   && ($unsigned(w_row) < CALC_W'(SCREEN_HEIGHT));

    // Expiry is judged on the incremented value so the wait lasts
    // TIMEOUT-1 cycles and a stalled column costs TIMEOUT+1 cycles overall.
    assign w_wd_next   = r_watchdog + 1'b1;
    assign w_wd_expire = (w_wd_next == WD_W'(TIMEOUT - 1));

    assign w_skip_sat    = (r_skipped == 8'hFF) ? r_skipped : r_skipped + 8'd1;
    assign w_unused_frac = ^eval_result[FRAC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_col          <= '0;
            r_watchdog     <= '0;
            r_eval_x       <= '0;
            r_parser_start <= 1'b0;
            r_eval_start   <= 1'b0;
            r_pixel_we     <= 1'b0;
            r_pixel_x      <= '0;
            r_pixel_y      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_skipped      <= '0;
        end else begin
            r_parser_start <= 1'b0;
            r_eval_start   <= 1'b0;
            r_pixel_we     <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state        <= S_PARSE;
                        r_col          <= '0;
                        r_eval_x       <= X_START;
                        r_skipped      <= '0;
                        r_done         <= 1'b0;
                        r_busy         <= 1'b1;
                        r_parser_start <= 1'b1;
                    end
                end
                S_PARSE: begin
                    r_state <= S_PARSE_GAP;
                end
                // parser_ready may still be high from a previous run here.
                S_PARSE_GAP: begin
                    r_state <= S_WAIT_PARSE;
                end
                S_WAIT_PARSE: begin
                    if (parser_ready) begin
                        r_state      <= S_EVAL;
                        r_eval_start <= 1'b1;
                    end
                end
                S_EVAL: begin
                    r_watchdog <= '0;
                    r_state    <= S_WAIT_EVAL;
                end
                S_WAIT_EVAL: begin
                    r_watchdog <= w_wd_next;
                    // The result is consumed here, in the eval_done cycle, so
                    // the write strobe is registered and lands in WRITE.
                    if (eval_done) begin
                        r_state <= S_WRITE;
                        if (eval_error) begin
                            r_skipped <= w_skip_sat;
                        end else if (w_row_ok) begin
                            r_pixel_we <= 1'b1;
                            r_pixel_x  <= r_col;
                            r_pixel_y  <= w_row[ROW_W-1:0];
                        end
                    end else if (w_wd_expire) begin
                        r_state   <= S_NEXT;
                        r_skipped <= w_skip_sat;
                    end
                end
                S_WRITE: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_col == COL_W'(SCREEN_WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_col        <= r_col + 1'b1;
                        r_eval_x     <= r_eval_x + X_STEP;
                        r_state      <= S_EVAL;
                        r_eval_start <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign parser_start  = r_parser_start;
    assign eval_start    = r_eval_start;
    assign eval_x        = r_eval_x;
    assign pixel_we      = r_pixel_we;
    assign pixel_x       = r_pixel_x;
    assign pixel_y       = r_pixel_y;
    assign busy          = r_busy;
    assign done          = r_done;
    assign skipped_count = r_skipped;

endmodule
